// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio transmit path.
//   - audio_mode_e   : frame format encodings carried on i_mode
//   - sample_pair_t  : left/right sample pair, each field MSB-aligned in
//                      PAIR_MAX_W bits (low bits zero), i.e. the slot image
//                      for a PAIR_MAX_W-bit slot
//   - mode helpers   : decode mono-sum and left-justified variants
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_I2S      = 2'd0,
        MODE_LJ       = 2'd1,
        MODE_I2S_MONO = 2'd2,
        MODE_LJ_MONO  = 2'd3
    } audio_mode_e;

    // Widest sample the pair struct can carry; SAMPLE_W must not exceed it.
    localparam int PAIR_MAX_W = 32;

    typedef struct packed {
        logic [PAIR_MAX_W-1:0] left;
        logic [PAIR_MAX_W-1:0] right;
    } sample_pair_t;

    function automatic logic mode_is_mono(input logic [1:0] m);
        return (m == MODE_I2S_MONO) || (m == MODE_LJ_MONO);
    endfunction

    function automatic logic mode_is_lj(input logic [1:0] m);
        return (m == MODE_LJ) || (m == MODE_LJ_MONO);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous FIFO for packed sample pairs.
//   i_clk, i_rst : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write strobe / data (ignored when full)
//   pop,  rdata  : read strobe (ignored when empty) / head-of-queue data
//   level        : registered occupancy 0..DEPTH
//   full, empty  : registered flags, consistent with level
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: ;
        endcase
    end

    // Storage carries no reset; only pointers and flags define contents.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/i2s_tx_param.sv
// i2s_tx_param: parametrised I2S / left-justified stereo transmitter.
//   i_clk, i_rst          : single fast clock, synchronous active-high reset
//   i_mode                : 0 I2S, 1 LJ, 2 I2S mono-sum, 3 LJ mono-sum;
//                           sampled at frame start only
//   s_valid/s_ready       : sample-pair handshake into the FIFO
//   s_left, s_right       : signed samples, SAMPLE_W bits
//   audio_mclk            : i_clk / (2*MCLK_HALF)
//   audio_lrck, audio_dac : word select (0 = left) and MSB-first data
//   o_level               : FIFO occupancy
//   o_underrun, o_frame   : one-cycle pulses the cycle after a frame start
module i2s_tx_param
    import audio_pkg::*;
#(
    parameter int SAMPLE_W      = 16,
    parameter int SLOT_BITS     = 32,
    parameter int MCLK_HALF     = 3,
    parameter int MCLK_PER_BIT  = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [1:0]                    i_mode,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    output logic                          audio_mclk,
    output logic                          audio_lrck,
    output logic                          audio_dac,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun,
    output logic                          o_frame
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int MC_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int PB_W = (MCLK_PER_BIT > 1) ? $clog2(MCLK_PER_BIT) : 1;
    localparam int BC_W = $clog2(FRAME_BITS);
    localparam int PW   = 2 * SAMPLE_W;

    // ---------------- clock dividers and frame counter ----------------
    logic [MC_W-1:0] mclk_cnt;
    logic [PB_W-1:0] per_cnt;
    logic [BC_W-1:0] bit_cnt, bit_nxt;
    logic            mclk_wrap, mclk_fall, bit_tick, frame_start;

    assign mclk_wrap   = (mclk_cnt == MC_W'(MCLK_HALF - 1));
    assign mclk_fall   = mclk_wrap && audio_mclk;
    assign bit_tick    = mclk_fall && (per_cnt == PB_W'(MCLK_PER_BIT - 1));
    assign frame_start = bit_tick && (bit_cnt == BC_W'(FRAME_BITS - 1));
    assign bit_nxt     = frame_start ? '0 : bit_cnt + BC_W'(1);

    // ---------------- sample FIFO ----------------
    logic [PW-1:0] fifo_rdata;
    logic          fifo_full, fifo_empty, push, pop;

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;
    assign pop     = frame_start && !fifo_empty;

    audio_sample_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .wdata ({s_left, s_right}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (o_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- frame image build ----------------
    logic [PW-1:0]              last_pair, src_pair;
    logic signed [SAMPLE_W-1:0] src_l, src_r, slot_l, slot_r;
    logic signed [SAMPLE_W:0]   mono_sum;
    sample_pair_t               img;
    logic [SLOT_BITS-1:0]       slot_lw, slot_rw;
    logic [FRAME_BITS-1:0]      frame_img, shreg;

    // An empty FIFO at frame start replays the last popped pair or silence.
    always_comb begin
        src_pair = last_pair;
        if (!fifo_empty)
            src_pair = fifo_rdata;
        else if (UNDERRUN_ZERO != 0)
            src_pair = '0;
    end

    assign src_l = src_pair[PW-1:SAMPLE_W];
    assign src_r = src_pair[SAMPLE_W-1:0];

    // One extra bit keeps the sum exact; dropping its LSB is the >>> 1.
    assign mono_sum = {src_l[SAMPLE_W-1], src_l} + {src_r[SAMPLE_W-1], src_r};
    assign slot_l   = mode_is_mono(i_mode) ? mono_sum[SAMPLE_W:1] : src_l;
    assign slot_r   = mode_is_mono(i_mode) ? mono_sum[SAMPLE_W:1] : src_r;

    always_comb begin
        img.left  = PAIR_MAX_W'($unsigned(slot_l)) << (PAIR_MAX_W - SAMPLE_W);
        img.right = PAIR_MAX_W'($unsigned(slot_r)) << (PAIR_MAX_W - SAMPLE_W);
    end

    // Fit the MSB-aligned struct fields to the slot width; the dropped or
    // appended bits are all padding zeros since SAMPLE_W <= SLOT_BITS.
    generate
        if (SLOT_BITS == PAIR_MAX_W) begin : g_slot_eq
            assign slot_lw = img.left;
            assign slot_rw = img.right;
        end else if (SLOT_BITS > PAIR_MAX_W) begin : g_slot_wide
            assign slot_lw = {img.left,  {(SLOT_BITS - PAIR_MAX_W){1'b0}}};
            assign slot_rw = {img.right, {(SLOT_BITS - PAIR_MAX_W){1'b0}}};
        end else begin : g_slot_narrow
            assign slot_lw = img.left[PAIR_MAX_W-1 -: SLOT_BITS];
            assign slot_rw = img.right[PAIR_MAX_W-1 -: SLOT_BITS];
        end
    endgenerate

    assign frame_img = {slot_lw, slot_rw};

    // ---------------- sequential core ----------------
    // shreg always holds the bits still to be sent. LJ emits the new frame's
    // MSB on bit 0; I2S emits the one bit left over from the previous frame
    // (its last right-slot padding bit) and starts the new frame on bit 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mclk_cnt   <= '0;
            per_cnt    <= '0;
            bit_cnt    <= BC_W'(FRAME_BITS - 1);
            audio_mclk <= 1'b0;
            audio_lrck <= 1'b0;
            audio_dac  <= 1'b0;
            o_frame    <= 1'b0;
            o_underrun <= 1'b0;
            last_pair  <= '0;
            shreg      <= '0;
        end else begin
            mclk_cnt <= mclk_wrap ? '0 : mclk_cnt + MC_W'(1);
            if (mclk_wrap)
                audio_mclk <= ~audio_mclk;
            if (mclk_fall)
                per_cnt <= bit_tick ? '0 : per_cnt + PB_W'(1);

            o_frame    <= frame_start;
            o_underrun <= frame_start && fifo_empty;

            if (bit_tick) begin
                bit_cnt    <= bit_nxt;
                audio_lrck <= (bit_nxt >= BC_W'(SLOT_BITS));
                if (frame_start) begin
                    if (!fifo_empty)
                        last_pair <= fifo_rdata;
                    if (mode_is_lj(i_mode)) begin
                        audio_dac <= frame_img[FRAME_BITS-1];
                        shreg     <= frame_img << 1;
                    end else begin
                        audio_dac <= shreg[FRAME_BITS-1];
                        shreg     <= frame_img;
                    end
                end else begin
                    audio_dac <= shreg[FRAME_BITS-1];
                    shreg     <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_param.sv
module tb_i2s_tx_param;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_mode;
    logic        s_valid;
    logic [15:0] s_left, s_right;

    logic        s_ready, audio_mclk, audio_lrck, audio_dac, o_underrun, o_frame;
    logic [2:0]  o_level;
    logic        z_ready, z_mclk, z_lrck, z_dac, z_underrun, z_frame;
    logic [2:0]  z_level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    i2s_tx_param #(.UNDERRUN_ZERO(0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_dac(audio_dac),
        .o_level(o_level), .o_underrun(o_underrun), .o_frame(o_frame)
    );

    i2s_tx_param #(.UNDERRUN_ZERO(1)) dut_z (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode),
        .s_valid(s_valid), .s_ready(z_ready), .s_left(s_left), .s_right(s_right),
        .audio_mclk(z_mclk), .audio_lrck(z_lrck), .audio_dac(z_dac),
        .o_level(z_level), .o_underrun(z_underrun), .o_frame(z_frame)
    );

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame();
        int guard = 0;
        while (o_frame !== 1'b1 && guard < 4000) begin
            step(1);
            guard++;
        end
        chk("frame_wait", 64'(guard < 4000), 64'd1);
    endtask

    // Records one full frame starting at the o_frame cycle (DAC bit 0).
    task automatic capture(output logic [63:0] d, output logic [63:0] dz,
                           output logic [63:0] lr, output int tf,
                           output logic u, output logic uz);
        wait_frame();
        tf = cyc;
        u  = o_underrun;
        uz = z_underrun;
        for (int k = 0; k < 64; k++) begin
            d[63-k]  = audio_dac;
            dz[63-k] = z_dac;
            lr[63-k] = audio_lrck;
            if (k != 63) step(24);
        end
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1; s_left = l; s_right = r;
        step(1);
        s_valid = 1'b0;
    endtask

    localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

    logic [63:0] d, dz, lr;
    logic        u, uz;
    int          tf, tf_prev, t0;

    initial begin
        i_rst = 1'b1; i_mode = 2'd0; s_valid = 1'b0; s_left = '0; s_right = '0;
        step(3);
        chk("rst_outputs", 64'({audio_mclk, audio_lrck, audio_dac, o_underrun, o_frame}), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);

        // first frame, I2S
        i_rst = 1'b0;
        t0 = cyc;
        chk("ready_after_rst", 64'(s_ready), 64'd1);
        push_pair(16'h8001, 16'h7FFE);
        chk("level_after_push", 64'(o_level), 64'd1);
        capture(d, dz, lr, tf, u, uz);
        chk("first_frame_latency", 64'(tf - t0), 64'd24);
        chk("i2s_underrun", 64'(u), 64'd0);
        chk("i2s_dac", d, 64'h4000_8000_3FFF_0000);
        chk("i2s_lrck", lr, LR_EXP);
        tf_prev = tf;

        // left-justified
        i_mode = 2'd1;
        push_pair(16'h8001, 16'h7FFE);
        capture(d, dz, lr, tf, u, uz);
        chk("frame_period", 64'(tf - tf_prev), 64'd1536);
        chk("lj_underrun", 64'(u), 64'd0);
        chk("lj_dac", d, 64'h8001_0000_7FFE_0000);
        chk("lj_lrck", lr, LR_EXP);
        tf_prev = tf;

        // underrun: repeat vs zero
        capture(d, dz, lr, tf, u, uz);
        chk("ur_period", 64'(tf - tf_prev), 64'd1536);
        chk("ur_pulse", 64'(u), 64'd1);
        chk("ur_pulse_z", 64'(uz), 64'd1);
        chk("ur_repeat_dac", d, 64'h8001_0000_7FFE_0000);
        chk("ur_zero_dac", dz, 64'd0);

        // fill the FIFO, hold s_valid across the frame-start pop
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h8000, 16'h8000);
        push_pair(16'h0003, 16'hFFFC);
        push_pair(16'hA5A5, 16'h5A5A);
        chk("full_level", 64'(o_level), 64'd4);
        chk("full_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222;
        wait_frame();
        chk("pop_full_level", 64'(o_level), 64'd3);
        chk("pop_full_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        capture(d, dz, lr, tf, u, uz);
        chk("fifo_p1_dac", d, 64'h1234_0000_ABCD_0000);

        // mono modes
        i_mode = 2'd3;
        capture(d, dz, lr, tf, u, uz);
        chk("mono_min_dac", d, 64'h8000_0000_8000_0000);
        i_mode = 2'd2;
        capture(d, dz, lr, tf, u, uz);
        chk("mono_neg_dac", d, 64'h7FFF_8000_7FFF_8000);
        chk("mono_neg_dac_z", dz, 64'h7FFF_8000_7FFF_8000);
        i_mode = 2'd0;
        capture(d, dz, lr, tf, u, uz);
        chk("p4_underrun", 64'(u), 64'd0);
        chk("p4_dac", d, 64'h52D2_8000_2D2D_0000);
        chk("drained_level", 64'(o_level), 64'd0);
        capture(d, dz, lr, tf, u, uz);
        chk("p4_repeat_underrun", 64'(u), 64'd1);
        chk("p4_repeat_dac", d, 64'h52D2_8000_2D2D_0000);
        chk("p4_zero_dac", dz, 64'd0);

        // reset in bit 20 of a left slot
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h0F0F, 16'hF0F0);
        wait_frame();
        step(20 * 24 + 5);
        chk("pre_rst_level", 64'(o_level), 64'd1);
        chk("pre_rst_lrck", 64'(audio_lrck), 64'd0);
        i_rst = 1'b1;
        step(1);
        chk("midrst_outputs", 64'({audio_mclk, audio_lrck, audio_dac, o_underrun, o_frame}), 64'd0);
        chk("midrst_level", 64'(o_level), 64'd0);
        i_rst = 1'b0;
        t0 = cyc;
        chk("midrst_ready", 64'(s_ready), 64'd1);
        push_pair(16'h8001, 16'h7FFE);
        capture(d, dz, lr, tf, u, uz);
        chk("restart_latency", 64'(tf - t0), 64'd24);
        chk("restart_underrun", 64'(u), 64'd0);
        chk("restart_dac", d, 64'h4000_8000_3FFF_0000);
        chk("restart_lrck", lr, LR_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
